// File: rtl/cla4_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : cla4_if
// Brief    : Operand/result bundle for the 4-bit carry-lookahead adder.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface cla4_if;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       cout;
    logic       ovf;
    logic       pg;
    logic       gg;

    modport master (
        output a, b, cin,
        input  s, cout, ovf, pg, gg
    );

    modport slave (
        input  a, b, cin,
        output s, cout, ovf, pg, gg
    );
endinterface
`default_nettype wire

// File: rtl/cla4.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : cla4
// Brief    : 4-bit carry-lookahead adder, two-level carries, registered outputs.
// Revision : 1.0
// ----------------------------------------------------------------------------
module cla4 (
    input  wire logic clk,
    input  wire logic rst,
    cla4_if.slave     bus
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;
    logic [3:0] w_s;
    logic       w_pg;
    logic       w_gg;

    logic [3:0] r_s;
    logic       r_cout;
    logic       r_ovf;
    logic       r_pg;
    logic       r_gg;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_bit
            assign w_g[i] = bus.a[i] & bus.b[i];
            assign w_p[i] = bus.a[i] ^ bus.b[i];
            assign w_s[i] = w_p[i] ^ w_c[i];
        end
    endgenerate

    // Every carry is a flat sum-of-products of g/p and cin; none depends on another carry.
    assign w_c[0] = bus.cin;
    assign w_c[1] = w_g[0]
                  | (w_p[0] & bus.cin);
    assign w_c[2] = w_g[1]
                  | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & bus.cin);
    assign w_c[3] = w_g[2]
                  | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & bus.cin);
    assign w_c[4] = w_g[3]
                  | (w_p[3] & w_g[2])
                  | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & bus.cin);

    assign w_pg = &w_p;
    assign w_gg = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s    <= 4'b0000;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_pg   <= 1'b0;
            r_gg   <= 1'b0;
        end else begin
            r_s    <= w_s;
            r_cout <= w_c[4];
            r_ovf  <= w_c[3] ^ w_c[4];
            r_pg   <= w_pg;
            r_gg   <= w_gg;
        end
    end

    assign bus.s    = r_s;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
    assign bus.pg   = r_pg;
    assign bus.gg   = r_gg;
endmodule
`default_nettype wire

// File: tb/tb_cla4.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_cla4
// Brief    : Self-checking bench for cla4; arithmetic reference model.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_cla4;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    cla4_if bus ();

    cla4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed as {cout, ovf, pg, gg, s[3:0]}, derived from integer arithmetic.
    function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic ci);
        int  total;
        int  sa;
        int  sb;
        int  ssum;
        logic ov;
        logic p;
        logic g;
        total = int'(a) + int'(b) + int'(ci);
        sa    = (a > 4'd7) ? int'(a) - 16 : int'(a);
        sb    = (b > 4'd7) ? int'(b) - 16 : int'(b);
        ssum  = sa + sb + int'(ci);
        ov    = (ssum > 7) || (ssum < -8);
        p     = ((a ^ b) == 4'hF);
        g     = (int'(a) + int'(b)) > 15;
        return {total[4], ov, p, g, total[3:0]};
    endfunction

    function automatic logic [7:0] observed();
        return {bus.cout, bus.ovf, bus.pg, bus.gg, bus.s};
    endfunction

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci);
        @(negedge clk);
        bus.a   = a;
        bus.b   = b;
        bus.cin = ci;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.a = 4'b0101; bus.b = 4'b0110; bus.cin = 1'b0;
        #1;
        n_checks++;
        if (observed() !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_async got=%b want=%b", observed(), 8'h00);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (observed() !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold[%0d] got=%b want=%b", i, observed(), 8'h00);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        n_checks++;
        if (observed() !== 8'b0100_1011) begin
            n_fail++;
            $display("FAIL reset_release got=%b want=%b", observed(), 8'b0100_1011);
        end
    endtask

    task automatic test_basic();
        logic [3:0] av [3];
        logic [7:0] ev [3];
        av = '{4'b0001, 4'b0010, 4'b0100};
        ev = '{8'b0000_0010, 8'b0000_0100, 8'b0100_1000};
        for (int i = 0; i < 3; i++) begin
            drive(av[i], av[i], 1'b0);
            step();
            n_checks++;
            if (observed() !== ev[i]) begin
                n_fail++;
                $display("FAIL basic[%0d] got=%b want=%b", i, observed(), ev[i]);
            end
        end
    endtask

    task automatic test_carry_out();
        drive(4'b0011, 4'b1111, 1'b0);
        step();
        n_checks++;
        if (observed() !== 8'b1001_0010) begin
            n_fail++;
            $display("FAIL carry_out got=%b want=%b", observed(), 8'b1001_0010);
        end
        drive(4'b1111, 4'b0001, 1'b0);
        step();
        n_checks++;
        if (observed() !== 8'b1001_0000) begin
            n_fail++;
            $display("FAIL wrap_15p1 got=%b want=%b", observed(), 8'b1001_0000);
        end
    endtask

    task automatic test_propagate();
        drive(4'b1010, 4'b0101, 1'b1);
        step();
        n_checks++;
        if (observed() !== 8'b1010_0000) begin
            n_fail++;
            $display("FAIL propagate_cin1 got=%b want=%b", observed(), 8'b1010_0000);
        end
        drive(4'b1010, 4'b0101, 1'b0);
        step();
        n_checks++;
        if (observed() !== 8'b0010_1111) begin
            n_fail++;
            $display("FAIL propagate_cin0 got=%b want=%b", observed(), 8'b0010_1111);
        end
    endtask

    task automatic test_latency();
        logic [7:0] e1;
        logic [7:0] e2;
        e1 = model(4'd6, 4'd7, 1'b0);
        e2 = model(4'd9, 4'd12, 1'b1);
        drive(4'd6, 4'd7, 1'b0);
        step();
        n_checks++;
        if (observed() !== e1) begin
            n_fail++;
            $display("FAIL latency_first got=%b want=%b", observed(), e1);
        end
        #2;
        bus.a = 4'd9; bus.b = 4'd12; bus.cin = 1'b1;
        #1;
        n_checks++;
        if (observed() !== e1) begin
            n_fail++;
            $display("FAIL latency_hold got=%b want=%b", observed(), e1);
        end
        step();
        n_checks++;
        if (observed() !== e2) begin
            n_fail++;
            $display("FAIL latency_next got=%b want=%b", observed(), e2);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] ez;
        ez = model(4'd3, 4'd2, 1'b1);
        drive(4'd13, 4'd14, 1'b1);
        step();
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (observed() !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_async got=%b want=%b", observed(), 8'h00);
        end
        step();
        n_checks++;
        if (observed() !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_hold got=%b want=%b", observed(), 8'h00);
        end
        drive(4'd3, 4'd2, 1'b1);
        rst = 1'b0;
        step();
        n_checks++;
        if (observed() !== ez) begin
            n_fail++;
            $display("FAIL reset_mid_resume got=%b want=%b", observed(), ez);
        end
    endtask

    task automatic test_exhaustive();
        logic [7:0] e;
        for (int k = 0; k < 512; k++) begin
            logic [8:0] v;
            v = 9'(k);
            e = model(v[3:0], v[7:4], v[8]);
            drive(v[3:0], v[7:4], v[8]);
            step();
            n_checks++;
            if (observed() !== e) begin
                n_fail++;
                $display("FAIL exhaustive a=%0d b=%0d cin=%0d got=%b want=%b",
                         v[3:0], v[7:4], v[8], observed(), e);
            end
            n_checks++;
            if (bus.cout !== (bus.gg | (bus.pg & v[8]))) begin
                n_fail++;
                $display("FAIL group_invariant a=%0d b=%0d cin=%0d cout=%b gg=%b pg=%b",
                         v[3:0], v[7:4], v[8], bus.cout, bus.gg, bus.pg);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rc;
        logic [7:0] e;
        for (int k = 0; k < 200; k++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            e  = model(ra, rb, rc);
            drive(ra, rb, rc);
            step();
            n_checks++;
            if (observed() !== e) begin
                n_fail++;
                $display("FAIL random a=%0d b=%0d cin=%0d got=%b want=%b",
                         ra, rb, rc, observed(), e);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.a    = 4'b0000;
        bus.b    = 4'b0000;
        bus.cin  = 1'b0;
        test_reset();
        test_basic();
        test_carry_out();
        test_propagate();
        test_latency();
        test_reset_mid();
        test_exhaustive();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
